// File: rtl/pe_ns_pkg.sv
// Shared encodings for the PE namespace writer: FSM states, namespace selects
// and the address-wrap mask helper.
package pe_ns_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic NS_DATA   = 1'b0;
  localparam logic NS_WEIGHT = 1'b1;

  // All-ones mask covering an address of the given width.
  function automatic int unsigned addr_mask(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/ns_wr_counter.sv
// Write pointer that wraps at the selected namespace depth, plus remaining-word down-counter.
// State updates one cycle after load/step; zero_nxt is combinational on the current step.
module ns_wr_counter
  import pe_ns_pkg::*;
#(
  parameter int dataAddrLen   = 5,
  parameter int weightAddrLen = 5,
  parameter int maxAddrLen    = 5,
  parameter int cntLen        = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  ns_sel,
  input  logic [maxAddrLen-1:0] load_ptr,
  input  logic [cntLen-1:0]     load_cnt,
  output logic [maxAddrLen-1:0] ptr,
  output logic                  zero_nxt
);

  localparam logic [maxAddrLen-1:0] DATA_MASK   = maxAddrLen'(addr_mask(dataAddrLen));
  localparam logic [maxAddrLen-1:0] WEIGHT_MASK = maxAddrLen'(addr_mask(weightAddrLen));

  logic [cntLen-1:0]     cnt;
  logic [cntLen-1:0]     cnt_nxt;
  logic [maxAddrLen-1:0] wrap_mask;
  logic [maxAddrLen-1:0] ptr_inc;

  always_comb begin
    wrap_mask = (ns_sel == NS_WEIGHT) ? WEIGHT_MASK : DATA_MASK;
    ptr_inc   = (ptr + maxAddrLen'(1)) & wrap_mask;
    cnt_nxt   = step ? (cnt - cntLen'(1)) : cnt;
  end

  // High when the step taken this cycle consumes the final word.
  assign zero_nxt = (cnt_nxt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (load) begin
      ptr <= load_ptr;
      cnt <= load_cnt;
    end else if (step) begin
      ptr <= ptr_inc;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/pe_ns_writer.sv
// Fills a PE data or weight buffer from a valid/ready stream; each beat writes one cycle later.
// in_ready is held high for the whole LOAD phase, so in_valid low simply stalls the load.
module pe_ns_writer
  import pe_ns_pkg::*;
#(
  parameter int dataLen       = 32,
  parameter int dataAddrLen   = 5,
  parameter int weightAddrLen = 5,
  parameter int maxAddrLen    = 5,
  parameter int cntLen        = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     ns_sel,
  input  logic [maxAddrLen-1:0]    base_addr,
  input  logic [cntLen-1:0]        num_words,
  input  logic                     in_valid,
  input  logic [dataLen-1:0]       in_word,
  output logic                     in_ready,
  output logic                     data_wrt,
  output logic [dataAddrLen-1:0]   data_wrt_addr,
  output logic [dataLen-1:0]       data_in,
  output logic                     weight_wrt,
  output logic [weightAddrLen-1:0] weight_wrt_addr,
  output logic [dataLen-1:0]       weight_in,
  output logic                     busy,
  output logic                     done
);

  state_t                state;
  state_t                state_nxt;
  logic                  ns_q;
  logic                  start_cmd;
  logic                  accept;
  logic                  cnt_zero;
  logic [maxAddrLen-1:0] ptr;

  assign start_cmd = (state == IDLE) && start;
  assign accept    = in_valid && in_ready;

  ns_wr_counter #(
    .dataAddrLen  (dataAddrLen),
    .weightAddrLen(weightAddrLen),
    .maxAddrLen   (maxAddrLen),
    .cntLen       (cntLen)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (start_cmd),
    .step    (accept),
    .ns_sel  (ns_q),
    .load_ptr(base_addr),
    .load_cnt(num_words),
    .ptr     (ptr),
    .zero_nxt(cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_words == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept && cnt_zero) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Namespace is frozen for the whole command so the pointer wrap and port choice stay consistent.
  always_ff @(posedge clk) begin
    if (reset) begin
      ns_q <= NS_DATA;
    end else if (start_cmd) begin
      ns_q <= ns_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_wrt        <= 1'b0;
      data_wrt_addr   <= '0;
      data_in         <= '0;
      weight_wrt      <= 1'b0;
      weight_wrt_addr <= '0;
      weight_in       <= '0;
    end else begin
      data_wrt   <= accept && (ns_q == NS_DATA);
      weight_wrt <= accept && (ns_q == NS_WEIGHT);
      if (accept && (ns_q == NS_DATA)) begin
        data_wrt_addr <= ptr[dataAddrLen-1:0];
        data_in       <= in_word;
      end
      if (accept && (ns_q == NS_WEIGHT)) begin
        weight_wrt_addr <= ptr[weightAddrLen-1:0];
        weight_in       <= in_word;
      end
    end
  end

endmodule

// File: tb/tb_pe_ns_writer.sv
// Directed bench for pe_ns_writer: expected writes are queued when beats are driven
// and popped when a buffer write appears, checking cycle, port, address and word.
module tb_pe_ns_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ns_sel;
  logic [4:0]  base_addr;
  logic [5:0]  num_words;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        data_wrt;
  logic [4:0]  data_wrt_addr;
  logic [31:0] data_in;
  logic        weight_wrt;
  logic [4:0]  weight_wrt_addr;
  logic [31:0] weight_in;
  logic        busy;
  logic        done;

  typedef struct {
    int          cyc;
    bit          ns;
    int          addr;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  pe_ns_writer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .ns_sel         (ns_sel),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .in_valid       (in_valid),
    .in_word        (in_word),
    .in_ready       (in_ready),
    .data_wrt       (data_wrt),
    .data_wrt_addr  (data_wrt_addr),
    .data_in        (data_in),
    .weight_wrt     (weight_wrt),
    .weight_wrt_addr(weight_wrt_addr),
    .weight_in      (weight_in),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Runs mid-cycle (negedge): every buffer write must match the oldest queued expectation.
  task automatic mon();
    exp_t e;
    chk("both_wrt", 32'(data_wrt & weight_wrt), 32'd0);
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missed_wrt", 32'(cyc), 32'(e.cyc));
    end
    if (data_wrt === 1'b1 || weight_wrt === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_wrt", {30'd0, data_wrt, weight_wrt}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
        chk("wr_ns", 32'(weight_wrt), 32'(e.ns));
        chk("wr_addr", 32'(e.ns ? weight_wrt_addr : data_wrt_addr), 32'(e.addr));
        chk("wr_word", e.ns ? weight_in : data_in, e.word);
      end
    end
  endtask

  // Leaves the bench 1 time unit after the next rising edge.
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_load(input bit ns, input int base, input int n, input logic [31:0] w0,
                          input int plen, input logic [15:0] vpat, input int glitch_at);
    int acc;
    acc       = 0;
    start     = 1'b1;
    ns_sel    = ns;
    base_addr = 5'(base);
    num_words = 6'(n);
    in_valid  = 1'b0;
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd1);
      chk("zero_ready", 32'(in_ready), 32'd0);
      tick();
      chk("zero_idle_done", 32'(done), 32'd0);
      chk("zero_idle_busy", 32'(busy), 32'd0);
      return;
    end
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    for (int p = 0; p < plen; p++) begin
      chk("load_ready", 32'(in_ready), 32'd1);
      if (p == glitch_at) begin
        start     = 1'b1;
        ns_sel    = ~ns;
        base_addr = 5'd7;
        num_words = 6'd1;
      end
      in_valid = vpat[p];
      in_word  = w0 + 32'(acc);
      if (vpat[p]) begin
        sb.push_back('{cyc + 1, ns, (base + acc) % 32, w0 + 32'(acc)});
        acc++;
      end
      tick();
      start = 1'b0;
      chk("load_done", 32'(done), 32'(acc == n));
    end
    in_valid = 1'b0;
    chk("end_ready", 32'(in_ready), 32'd0);
    chk("end_busy", 32'(busy), 32'd1);
    tick();
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    ns_sel    = 1'b0;
    base_addr = '0;
    num_words = '0;
    in_valid  = 1'b0;
    in_word   = '0;
    tick();
    tick();

    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data_wrt", 32'(data_wrt), 32'd0);
    chk("rst_weight_wrt", 32'(weight_wrt), 32'd0);
    chk("rst_data_addr", 32'(data_wrt_addr), 32'd0);
    chk("rst_weight_addr", 32'(weight_wrt_addr), 32'd0);
    chk("rst_data_in", data_in, 32'd0);
    chk("rst_weight_in", weight_in, 32'd0);
    reset = 1'b0;
    tick();

    // Data load, continuous stream.
    run_load(1'b0, 3, 4, 32'hA0, 4, 16'b1111, -1);
    // Weight load wrapping past the top of the buffer.
    run_load(1'b1, 30, 4, 32'hB0, 4, 16'b1111, -1);
    // Gapped stream: valid pattern 1,0,0,1,0,1 (bit 0 first).
    run_load(1'b0, 9, 3, 32'hC0, 6, 16'b101001, -1);
    // Zero-word command.
    run_load(1'b1, 5, 0, 32'h0, 0, 16'b0, -1);
    // Start re-pulsed mid-load with different arguments.
    run_load(1'b0, 12, 5, 32'hD0, 5, 16'b11111, 2);

    // Reset after two of five words; the beat offered during reset must not write.
    start     = 1'b1;
    ns_sel    = 1'b0;
    base_addr = 5'd20;
    num_words = 6'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_word  = 32'hE0 + 32'(i);
      sb.push_back('{cyc + 1, 1'b0, 20 + i, 32'hE0 + 32'(i)});
      tick();
    end
    reset    = 1'b1;
    in_word  = 32'hEE;
    tick();
    reset    = 1'b0;
    chk("mrst_ready", 32'(in_ready), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_data_wrt", 32'(data_wrt), 32'd0);
    tick();
    chk("mrst_idle_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();
    run_load(1'b0, 0, 2, 32'hF0, 2, 16'b11, -1);

    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
